// File: rtl/scomp_pkg.sv
// Shared definitions for the serial two's-complement negator array.
//   cnt_width()     width of the shared in-word bit counter
//   lane_state_t    per-lane COPY/INVERT state
//   SCOMP_*_DEF     default word length and lane count
package scomp_pkg;

    localparam int SCOMP_W_DEF  = 8;
    localparam int SCOMP_CH_DEF = 1;

    typedef enum logic {
        COPY   = 1'b0,
        INVERT = 1'b1
    } lane_state_t;

    // Guard keeps a 1-bit counter for degenerate widths; W>=2 gives $clog2(W).
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/scomp_lane.sv
// One serial lane: COPY/INVERT state, latched negate request, output register.
// Optional macro SCOMP_OVF_DETECT_EN adds the most-negative-value overflow pulse.
//
// Ports
//   t_clk    clock
//   r        synchronous active-high reset
//   valid    beat qualifier
//   first    current beat is bit 0 of the word
//   last     current beat is bit W-1 of the word
//   in_bit   serial input bit (LSB first)
//   neg      negate request (used only on the first beat)
//   out_bit  registered result bit, held across gaps
//   ovf      overflow pulse on the last beat (SCOMP_OVF_DETECT_EN only)
//
// state  | meaning
// COPY   | no 1 seen yet in this word; output follows input
// INVERT | a 1 has been seen; output is the inverted input when negating
module scomp_lane
    import scomp_pkg::*;
(
    input  logic t_clk,
    input  logic r,
    input  logic valid,
    input  logic first,
    input  logic last,
    input  logic in_bit,
    input  logic neg,
    output logic out_bit
`ifdef SCOMP_OVF_DETECT_EN
    ,
    output logic ovf
`endif
);

    lane_state_t state_q;
    lane_state_t state_d;
    lane_state_t state_cur;
    logic        neg_lat;
    logic        neg_eff;
    logic        out_d;

    always_comb begin
        // Bit 0 always starts fresh and uses the live negate request.
        state_cur = first ? COPY : state_q;
        neg_eff   = first ? neg : neg_lat;
        state_d   = state_q;
        out_d     = in_bit;
        if (neg_eff && (state_cur == INVERT)) begin
            out_d = ~in_bit;
        end
        if (valid) begin
            if (last) begin
                state_d = COPY;
            end else if ((state_cur == INVERT) || in_bit) begin
                state_d = INVERT;
            end else begin
                state_d = COPY;
            end
        end
    end

    always_ff @(posedge t_clk) begin
        if (r) begin
            state_q <= COPY;
            neg_lat <= 1'b0;
            out_bit <= 1'b0;
        end else begin
            state_q <= state_d;
            if (valid && first) begin
                neg_lat <= neg;
            end
            if (valid) begin
                out_bit <= out_d;
            end
        end
    end

`ifdef SCOMP_OVF_DETECT_EN
    // The only word whose first 1 is its MSB is 2^(W-1); negating it wraps.
    always_ff @(posedge t_clk) begin
        if (r) begin
            ovf <= 1'b0;
        end else begin
            ovf <= valid && last && neg_eff && in_bit && (state_cur == COPY);
        end
    end
`endif

endmodule

// File: rtl/serial_twos_comp_array.sv
// Multi-lane, word-framed serial two's-complement negator (LSB first).
// A shared counter frames W-bit words; each lane passes or negates its word.
// Optional macro SCOMP_OVF_DETECT_EN adds the ovf output.
//
// Ports
//   t_clk      clock
//   r          synchronous active-high reset
//   in_valid   qualifies in_bit (one bit per lane)
//   in_bit     CH serial input bits, lane c on bit c
//   neg        CH negate requests, sampled on bit 0 of a word
//   out_valid  registered in_valid
//   out_bit    CH serial result bits, 1-cycle latency
//   out_eow    marks the output beat carrying bit W-1
//   ovf        CH negation-overflow pulses (SCOMP_OVF_DETECT_EN only)
module serial_twos_comp_array
    import scomp_pkg::*;
#(
    parameter int W  = SCOMP_W_DEF,
    parameter int CH = SCOMP_CH_DEF
) (
    input  logic          t_clk,
    input  logic          r,
    input  logic          in_valid,
    input  logic [CH-1:0] in_bit,
    input  logic [CH-1:0] neg,
    output logic          out_valid,
    output logic [CH-1:0] out_bit,
    output logic          out_eow
`ifdef SCOMP_OVF_DETECT_EN
    ,
    output logic [CH-1:0] ovf
`endif
);

    localparam int            CW       = cnt_width(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    logic [CW-1:0] cnt;
    logic          first;
    logic          last;

    assign first = (cnt == '0);
    assign last  = (cnt == CNT_LAST);

    always_ff @(posedge t_clk) begin
        if (r) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            out_eow   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            out_eow   <= in_valid && last;
            if (in_valid) begin
                cnt <= last ? '0 : cnt + CW'(1);
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        scomp_lane u_lane (
            .t_clk   (t_clk),
            .r       (r),
            .valid   (in_valid),
            .first   (first),
            .last    (last),
            .in_bit  (in_bit[c]),
            .neg     (neg[c]),
            .out_bit (out_bit[c])
`ifdef SCOMP_OVF_DETECT_EN
            ,
            .ovf     (ovf[c])
`endif
        );
    end

endmodule

// File: tb/tb_serial_twos_comp_array.sv
module tb_serial_twos_comp_array;

    localparam int CH = 2;
    localparam int RN = 4;

    function automatic int rand_w(input int k);
        case (k)
            0:       return 2;
            1:       return 5;
            2:       return 8;
            default: return 16;
        endcase
    endfunction

    logic          t_clk = 1'b0;
    logic          r;
    logic          in_valid;
    logic [CH-1:0] in_bit;
    logic [CH-1:0] neg;
    logic          out_valid;
    logic [CH-1:0] out_bit;
    logic          out_eow;
`ifdef SCOMP_OVF_DETECT_EN
    logic [CH-1:0] ovf;
`endif

    logic       rin_valid  [RN];
    logic [3:0] rin_bit    [RN];
    logic [3:0] rneg       [RN];
    logic       rout_valid [RN];
    logic [3:0] rout_bit   [RN];
    logic       rout_eow   [RN];
`ifdef SCOMP_OVF_DETECT_EN
    logic [3:0] rovf       [RN];
`endif

    int errors = 0;
    int checks = 0;

    always #5 t_clk = ~t_clk;

    serial_twos_comp_array #(.W(8), .CH(CH)) dut (
        .t_clk     (t_clk),
        .r         (r),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .neg       (neg),
        .out_valid (out_valid),
        .out_bit   (out_bit),
        .out_eow   (out_eow)
`ifdef SCOMP_OVF_DETECT_EN
        ,
        .ovf       (ovf)
`endif
    );

    for (genvar k = 0; k < RN; k++) begin : g_rand
        localparam int WK = rand_w(k);
        serial_twos_comp_array #(.W(WK), .CH(4)) u_dut (
            .t_clk     (t_clk),
            .r         (r),
            .in_valid  (rin_valid[k]),
            .in_bit    (rin_bit[k]),
            .neg       (rneg[k]),
            .out_valid (rout_valid[k]),
            .out_bit   (rout_bit[k]),
            .out_eow   (rout_eow[k])
`ifdef SCOMP_OVF_DETECT_EN
            ,
            .ovf       (rovf[k])
`endif
        );
    end

    // Drives one 8-bit word on both lanes of the main instance and collects
    // what comes out; inputs change 1 time unit after each rising edge.
    task automatic drive_word(input logic [7:0] x0, input logic [7:0] x1,
                              input logic n0, input logic n1,
                              output logic [7:0] y0, output logic [7:0] y1,
                              output int eow_beat, output int nvalid,
                              output logic [1:0] ovf_eow, output logic [1:0] ovf_other);
        y0 = '0; y1 = '0; eow_beat = -1; nvalid = 0; ovf_eow = '0; ovf_other = '0;
        for (int b = 0; b < 8; b++) begin
            in_valid = 1'b1;
            in_bit   = {x1[b], x0[b]};
            neg      = {n1, n0};
            @(posedge t_clk); #1;
            if (out_valid) begin
                if (nvalid < 8) begin
                    y0[nvalid] = out_bit[0];
                    y1[nvalid] = out_bit[1];
                end
                nvalid++;
                if (out_eow) eow_beat = nvalid;
`ifdef SCOMP_OVF_DETECT_EN
                if (out_eow) ovf_eow = ovf;
                else         ovf_other = ovf_other | ovf;
`endif
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        r = 1'b1; in_valid = 1'b1; in_bit = '1; neg = '1;
        for (int k = 0; k < RN; k++) begin
            rin_valid[k] = 1'b0; rin_bit[k] = '0; rneg[k] = '0;
        end
        repeat (2) @(posedge t_clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_eow !== 1'b0) begin errors++; $display("FAIL reset_out_eow got=%b exp=0", out_eow); end
        checks++;
        if (out_bit !== 2'b00) begin errors++; $display("FAIL reset_out_bit got=%b exp=00", out_bit); end
`ifdef SCOMP_OVF_DETECT_EN
        checks++;
        if (ovf !== 2'b00) begin errors++; $display("FAIL reset_ovf got=%b exp=00", ovf); end
`endif
        r = 1'b0; in_valid = 1'b0; in_bit = '0; neg = '0;
    endtask

    task automatic test_basic();
        logic [7:0] y0, y1; int eb, nv; logic [1:0] oe, oo;
        drive_word(8'h06, 8'h06, 1'b1, 1'b0, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'hFA) begin errors++; $display("FAIL basic_lane0 got=%h exp=fa", y0); end
        checks++;
        if (y1 !== 8'h06) begin errors++; $display("FAIL basic_lane1 got=%h exp=06", y1); end
        checks++;
        if (nv !== 8) begin errors++; $display("FAIL basic_nvalid got=%0d exp=8", nv); end
        checks++;
        if (eb !== 8) begin errors++; $display("FAIL basic_eow_beat got=%0d exp=8", eb); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] y0, y1; int eb, nv; logic [1:0] oe, oo;
        drive_word(8'h00, 8'h80, 1'b1, 1'b0, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'h00) begin errors++; $display("FAIL b2b_zero got=%h exp=00", y0); end
        checks++;
        if (y1 !== 8'h80) begin errors++; $display("FAIL b2b_pass80 got=%h exp=80", y1); end
        drive_word(8'hFF, 8'h01, 1'b1, 1'b1, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'h01) begin errors++; $display("FAIL b2b_ff got=%h exp=01", y0); end
        checks++;
        if (y1 !== 8'hFF) begin errors++; $display("FAIL b2b_01 got=%h exp=ff", y1); end
        checks++;
        if (eb !== 8) begin errors++; $display("FAIL b2b_eow_beat got=%0d exp=8", eb); end
    endtask

    task automatic test_overflow();
        logic [7:0] y0, y1; int eb, nv; logic [1:0] oe, oo;
        drive_word(8'h80, 8'h7F, 1'b1, 1'b1, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'h80) begin errors++; $display("FAIL ovf_lane0_val got=%h exp=80", y0); end
        checks++;
        if (y1 !== 8'h81) begin errors++; $display("FAIL ovf_lane1_val got=%h exp=81", y1); end
`ifdef SCOMP_OVF_DETECT_EN
        checks++;
        if (oe !== 2'b01) begin errors++; $display("FAIL ovf_at_eow got=%b exp=01", oe); end
        checks++;
        if (oo !== 2'b00) begin errors++; $display("FAIL ovf_off_eow got=%b exp=00", oo); end
`endif
        drive_word(8'h7F, 8'h80, 1'b1, 1'b0, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'h81) begin errors++; $display("FAIL ovf_7f got=%h exp=81", y0); end
        checks++;
        if (y1 !== 8'h80) begin errors++; $display("FAIL ovf_pass80 got=%h exp=80", y1); end
`ifdef SCOMP_OVF_DETECT_EN
        checks++;
        if ((oe | oo) !== 2'b00) begin errors++; $display("FAIL ovf_none got=%b exp=00", oe | oo); end
`endif
    endtask

    task automatic test_gap();
        logic [7:0] x, y0, y1;
        int nv;
        x = 8'h05; y0 = '0; y1 = '0; nv = 0;
        for (int b = 0; b < 8; b++) begin
            if (b == 3) begin
                for (int g = 0; g < 3; g++) begin
                    in_valid = 1'b0;
                    in_bit   = 2'(g);
                    neg      = (g % 2 == 0) ? 2'b10 : 2'b01;
                    @(posedge t_clk); #1;
                    checks++;
                    if (out_valid !== 1'b0) begin errors++; $display("FAIL gap_valid_%0d got=%b exp=0", g, out_valid); end
                    checks++;
                    if (out_eow !== 1'b0) begin errors++; $display("FAIL gap_eow_%0d got=%b exp=0", g, out_eow); end
                    checks++;
                    if (out_bit !== 2'b10) begin errors++; $display("FAIL gap_hold_%0d got=%b exp=10", g, out_bit); end
                end
            end
            in_valid = 1'b1;
            in_bit   = {x[b], x[b]};
            neg      = (b == 0) ? 2'b01 : 2'b10;
            @(posedge t_clk); #1;
            if (out_valid && nv < 8) begin
                y0[nv] = out_bit[0];
                y1[nv] = out_bit[1];
                nv++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (y0 !== 8'hFB) begin errors++; $display("FAIL gap_lane0 got=%h exp=fb", y0); end
        checks++;
        if (y1 !== 8'h05) begin errors++; $display("FAIL gap_lane1 got=%h exp=05", y1); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] x, y0, y1; int eb, nv; logic [1:0] oe, oo;
        x = 8'hAA;
        for (int b = 0; b < 4; b++) begin
            in_valid = 1'b1; in_bit = {x[b], x[b]}; neg = 2'b11;
            @(posedge t_clk); #1;
        end
        r = 1'b1; in_valid = 1'b1; in_bit = 2'b11; neg = 2'b11;
        @(posedge t_clk); #1;
        r = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        checks++;
        if (out_eow !== 1'b0) begin errors++; $display("FAIL rmid_eow got=%b exp=0", out_eow); end
        checks++;
        if (out_bit !== 2'b00) begin errors++; $display("FAIL rmid_bit got=%b exp=00", out_bit); end
`ifdef SCOMP_OVF_DETECT_EN
        checks++;
        if (ovf !== 2'b00) begin errors++; $display("FAIL rmid_ovf got=%b exp=00", ovf); end
`endif
        drive_word(8'h03, 8'h03, 1'b1, 1'b0, y0, y1, eb, nv, oe, oo);
        checks++;
        if (y0 !== 8'hFD) begin errors++; $display("FAIL rmid_lane0 got=%h exp=fd", y0); end
        checks++;
        if (y1 !== 8'h03) begin errors++; $display("FAIL rmid_lane1 got=%h exp=03", y1); end
        checks++;
        if (eb !== 8) begin errors++; $display("FAIL rmid_eow_beat got=%0d exp=8", eb); end
    endtask

    task automatic test_random(input int k, input int nwords);
        int          wk;
        logic [15:0] mask, msb;
        logic [15:0] x [4];
        logic [15:0] y [4];
        logic [3:0]  n, ebits, held, eovf, vb;
        wk   = rand_w(k);
        mask = 16'((32'd1 << wk) - 1);
        msb  = 16'(32'd1 << (wk - 1));
        held = '0;
        for (int w = 0; w < nwords; w++) begin
            n = 4'($urandom_range(0, 15));
            for (int l = 0; l < 4; l++) begin
                case ($urandom_range(0, 7))
                    0:       x[l] = msb;
                    1:       x[l] = '0;
                    default: x[l] = 16'($urandom) & mask;
                endcase
                y[l] = n[l] ? ((~x[l] + 16'd1) & mask) : x[l];
            end
            for (int b = 0; b < wk; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) begin
                        rin_valid[k] = 1'b0;
                        rin_bit[k]   = 4'($urandom_range(0, 15));
                        rneg[k]      = 4'($urandom_range(0, 15));
                        @(posedge t_clk); #1;
                        checks++;
                        if (rout_valid[k] !== 1'b0 || rout_bit[k] !== held) begin
                            errors++;
                            $display("FAIL rand_gap w=%0d got v=%b bits=%b exp v=0 bits=%b", wk, rout_valid[k], rout_bit[k], held);
                        end
                    end
                end
                for (int l = 0; l < 4; l++) begin
                    vb[l]    = x[l][b];
                    ebits[l] = y[l][b];
                    eovf[l]  = (b == wk - 1) && n[l] && (x[l] == msb);
                end
                rin_valid[k] = 1'b1;
                rin_bit[k]   = vb;
                rneg[k]      = (b == 0) ? n : 4'($urandom_range(0, 15));
                @(posedge t_clk); #1;
                checks++;
                if (rout_valid[k] !== 1'b1 || rout_bit[k] !== ebits || rout_eow[k] !== (b == wk - 1)) begin
                    errors++;
                    $display("FAIL rand_beat w=%0d word=%0d bit=%0d got v=%b bits=%b eow=%b exp bits=%b eow=%b",
                             wk, w, b, rout_valid[k], rout_bit[k], rout_eow[k], ebits, (b == wk - 1));
                end
`ifdef SCOMP_OVF_DETECT_EN
                checks++;
                if (rovf[k] !== eovf) begin
                    errors++;
                    $display("FAIL rand_ovf w=%0d word=%0d bit=%0d got=%b exp=%b", wk, w, b, rovf[k], eovf);
                end
`endif
                held = ebits;
            end
        end
        rin_valid[k] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overflow();
        test_gap();
        test_reset_mid_word();
        for (int k = 0; k < RN; k++) begin
            test_random(k, 250);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_twos_comp_array.md
Name: serial_twos_comp_array

Overview:
Multi-channel, word-framed serial two's-complement negator. Each lane takes an LSB-first bit stream and either passes it through or negates it. Negation works by copying bits up to and including the first 1, then inverting every later bit. A shared bit counter frames words of W bits. Sits between the serial shift front-end and the serial accumulator in the bit-serial datapath.

Parameters:
W, 8, word length in bits (>=2)
CH, 1, number of independent serial lanes (>=1)

Ports:
t_clk  in  1  single clock, all state updates on rising edge
r  in  1  reset, synchronous, active-high
in_valid  in  1  qualifies in_bit; one bit per lane per valid cycle
in_bit  in  CH  serial input bits, LSB first, lane c on bit c
neg  in  CH  per-lane negate request, sampled only on bit 0 of a word
out_valid  out  1  registered copy of in_valid
out_bit  out  CH  serial result bits, LSB first
out_eow  out  1  high with the out_valid beat carrying bit W-1
ovf  out  CH  negation overflow pulse, present only with SCOMP_OVF_DETECT_EN

Behaviour:
- Reset (r=1 at edge):
  - cnt=0, all lane seen=0, neg_lat=0.
  - out_valid=0, out_bit=0, out_eow=0, ovf=0.
  - r overrides in_valid in the same cycle.
- Global counter cnt, $clog2(W) bits:
  - Advances only on in_valid.
  - Wraps W-1 -> 0.
  - Frame position is implicit; there is no start-of-word input.
- Per-lane FSM, two states:
  - COPY (seen=0): out = in.
  - INVERT (seen=1): out = ~in.
  - Negate is applied only when neg_eff=1. With neg_eff=0 the lane passes in_bit through and still tracks seen.
- On an in_valid beat with cnt==0:
  - neg_eff = neg[c] (current input, not the latch). neg_lat[c] <= neg[c].
  - seen treated as 0 for this bit.
- On an in_valid beat with cnt!=0: neg_eff = neg_lat[c]. neg changes mid-word are ignored.
- Transitions:
  - COPY -> INVERT after any valid beat with in_bit[c]=1.
  - INVERT holds until the word ends.
  - State returns to COPY at word boundary, i.e. the beat following cnt==W-1.
- Latency: exactly 1 cycle. out_bit, out_valid and out_eow are registered together.
- in_valid=0 (gap):
  - cnt, seen and neg_lat hold.
  - out_valid=0 and out_eow=0 next cycle.
  - out_bit holds its previous value.
- Arithmetic: result is (-x) mod 2^W for neg=1 and x for neg=0.
  - x=0 negates to 0 (lane never leaves COPY).
- Reset mid-word: partial word discarded. The next valid beat is bit 0.
- No backpressure; the consumer must accept every out_valid beat.

Optional Feature:
Macro SCOMP_OVF_DETECT_EN.
- Defined:
  - ovf[c] pulses for 1 cycle, coincident with out_eow, when neg_eff=1 and the lane's word is 2^(W-1) (most-negative value).
  - Detection condition: cnt==W-1, in_bit=1, seen=0.
  - Output bits are unchanged (wraps to 2^(W-1)). ovf resets to 0.
- Undefined: ovf port and detect logic are absent; all other behaviour identical.

Decomposition:
- Package scomp_pkg:
  - function cnt_width(W) returning $clog2(W).
  - lane state enum {COPY, INVERT}.
  - default constants SCOMP_W_DEF=8, SCOMP_CH_DEF=1.
- Sub-module scomp_lane: one lane's seen/neg_lat state and output register.
  - Inputs: bit, neg, first, last, valid.
  - Instantiated CH times by generate.
- The top holds the shared counter, first/last decode, and out_valid/out_eow registers.

Test Plan:
- W=8,CH=2. Lane0 0x06 neg=1, lane1 0x06 neg=0, 8 consecutive valid beats.
  - Lane0 out LSB-first 0,1,0,1,1,1,1,1 (0xFA).
  - Lane1 out 0,1,1,0,0,0,0,0 (0x06).
  - out_eow on 8th out_valid beat.
- 0x00 neg=1 -> 0x00; then 0xFF neg=1 -> 0x01 back-to-back with no gap. Verifies state clears at wrap.
- 0x80 neg=1 -> out 0x80; with SCOMP_OVF_DETECT_EN, ovf[0]=1 exactly with out_eow. 0x7F neg=1 -> 0x81, ovf=0.
- 0x05 neg=1 with in_valid low for 3 cycles after bit 2, and neg toggled during the gap.
  - Result 0xFB.
  - out_valid low 3 cycles, out_bit held; toggled neg has no effect.
- r=1 at bit 4 of a word. Next cycle all outputs 0. Next word 0x03 neg=1 -> 0xFD, correctly framed from bit 0.
- Random W in {2,5,8,16}, CH=4, 1000 words, random neg and valid gaps; scoreboard compares against (-x) mod 2^W or x.
